// File: rtl/uart_recv_cfg.sv
// uart_recv_cfg: configurable UART receiver (5..8 data bits, none/odd/even
// parity, 1 or 2 stop bits) with 3-sample majority voting, false-start
// rejection, parity/framing flags and a valid/ready output register.
//
// Ports:
//   sys_clk     system clock
//   sys_rst_n   asynchronous active-low reset
//   uart_rxd    serial line, idle high, asynchronous to sys_clk
//   uart_ready  consumer accepts uart_data this cycle
//   uart_valid  uart_data/par_err/frm_err hold a received frame
//   uart_data   received word, LSB first on the line, unused high bits 0
//   par_err     parity mismatch for the held frame (0 when PARITY = 0)
//   frm_err     a stop bit of the held frame was sampled 0
//   overrun     one-cycle pulse: a completed frame was dropped
//   fsm_state   current receiver state, for debug/observation
//
// Handshake: a frame is transferred in every cycle where uart_valid and
// uart_ready are both 1. While uart_valid = 1 and uart_ready = 0 the data
// and flags are frozen; a frame completing in that state is dropped and
// overrun pulses. A frame completing in a transfer cycle replaces the one
// being consumed, so uart_valid stays 1.
module uart_recv_cfg #(
    parameter logic [15:0] BPS_CNT   = 16'd434,
    parameter int          DATA_BITS = 8,
    parameter int          PARITY    = 0,
    parameter int          STOP_BITS = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    input  logic       uart_ready,
    output logic       uart_valid,
    output logic [7:0] uart_data,
    output logic       par_err,
    output logic       frm_err,
    output logic       overrun,
    output logic [2:0] fsm_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Three sample points centred on mid-bit; the vote is taken on the last.
    localparam logic [15:0] SMP_A    = BPS_CNT / 16'd2 - 16'd1;
    localparam logic [15:0] SMP_B    = BPS_CNT / 16'd2;
    localparam logic [15:0] SMP_C    = BPS_CNT / 16'd2 + 16'd1;
    localparam logic [15:0] LAST_CNT = BPS_CNT - 16'd1;

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    logic        rxd_s1;
    logic        rxd_s2;
    logic        rxd_s2_d;
    logic [2:0]  state;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_cnt;
    logic        smp_a;
    logic        smp_b;
    logic [7:0]  shift_data;
    logic        par_bit;
    logic        frm_acc;

    logic        fall_edge;
    logic        vote_pt;
    logic        bit_end;
    logic        vote;
    logic        frame_done;
    logic        par_calc;

    assign fall_edge  = !rxd_s2 && rxd_s2_d;
    assign vote_pt    = (clk_cnt == SMP_C);
    assign bit_end    = (clk_cnt == LAST_CNT);
    // Third sample is the live synchronizer output, so the vote lands in
    // the same cycle as the last sample.
    assign vote       = (smp_a & smp_b) | (smp_a & rxd_s2) | (smp_b & rxd_s2);
    assign frame_done = (state == S_STOP) && vote_pt && (bit_cnt == LAST_STOP);
    assign fsm_state  = state;

    always_comb begin
        par_calc = 1'b0;
        if (PARITY == 1) begin
            par_calc = ~((^shift_data) ^ par_bit);
        end else if (PARITY == 2) begin
            par_calc = (^shift_data) ^ par_bit;
        end
    end

    // Synchronizer and receive FSM. Synchronizer flops reset high so reset
    // release never looks like a start edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_s1     <= 1'b1;
            rxd_s2     <= 1'b1;
            rxd_s2_d   <= 1'b1;
            state      <= S_IDLE;
            clk_cnt    <= 16'd0;
            bit_cnt    <= 3'd0;
            smp_a      <= 1'b1;
            smp_b      <= 1'b1;
            shift_data <= 8'd0;
            par_bit    <= 1'b0;
            frm_acc    <= 1'b0;
        end else begin
            rxd_s1   <= uart_rxd;
            rxd_s2   <= rxd_s1;
            rxd_s2_d <= rxd_s2;
            if (state == S_IDLE) begin
                clk_cnt <= 16'd0;
                bit_cnt <= 3'd0;
                if (fall_edge) begin
                    state      <= S_START;
                    shift_data <= 8'd0;
                    par_bit    <= 1'b0;
                    frm_acc    <= 1'b0;
                end
            end else begin
                clk_cnt <= bit_end ? 16'd0 : clk_cnt + 16'd1;
                if (clk_cnt == SMP_A) smp_a <= rxd_s2;
                if (clk_cnt == SMP_B) smp_b <= rxd_s2;
                case (state)
                    S_START: begin
                        // A start bit that votes high was a glitch.
                        if (vote_pt && vote) begin
                            state <= S_IDLE;
                        end else if (bit_end) begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (vote_pt) shift_data[bit_cnt] <= vote;
                        if (bit_end) begin
                            if (bit_cnt == LAST_DATA) begin
                                bit_cnt <= 3'd0;
                                state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (vote_pt) par_bit <= vote;
                        if (bit_end) state <= S_STOP;
                    end
                    S_STOP: begin
                        if (vote_pt) begin
                            if (!vote) frm_acc <= 1'b1;
                            // Leave mid stop bit so a start edge in the
                            // second half of the stop bit is caught.
                            if (bit_cnt == LAST_STOP) state <= S_IDLE;
                        end else if (bit_end) begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Output register with overrun detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            uart_valid <= 1'b0;
            uart_data  <= 8'd0;
            par_err    <= 1'b0;
            frm_err    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                if (!uart_valid || uart_ready) begin
                    uart_valid <= 1'b1;
                    uart_data  <= shift_data;
                    par_err    <= par_calc;
                    frm_err    <= frm_acc | ~vote;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (uart_valid && uart_ready) begin
                uart_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_recv_cfg.sv
// Bench for uart_recv_cfg: an 8N1 and a 7E2 instance at 16 clocks per bit.
// A line-level driver builds frames from data/parity/stop choices, computes
// the expected word and flags from the framing rules and the expected
// completion cycle from the frame length, and a per-cycle model of the
// valid/ready register is compared against both DUTs on every falling edge.
module tb_uart_recv_cfg;

    localparam int B = 16;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [1:0]  rxd       = 2'b11;
    logic [1:0]  ready     = 2'b11;
    logic [1:0]  valid;
    logic [1:0]  pe;
    logic [1:0]  fe;
    logic [1:0]  ovr;
    logic [15:0] data_bus;
    logic [2:0]  st0;
    logic [2:0]  st1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // {id, done cycle[31:0], data[7:0], par_err, frm_err}
    logic [42:0] exp_q[$];

    logic [1:0] m_valid = 2'b00;
    logic [1:0] m_pe    = 2'b00;
    logic [1:0] m_fe    = 2'b00;
    logic [1:0] m_ovr   = 2'b00;
    logic [7:0] m_data [2] = '{8'h00, 8'h00};

    logic [1:0] prev_valid = 2'b00;
    int         rise_cyc [2] = '{0, 0};
    int         fall_cyc [2] = '{0, 0};
    int         rise_cnt [2] = '{0, 0};
    int         ovr_cnt  [2] = '{0, 0};
    logic [7:0] rise_data [2] = '{8'h00, 8'h00};
    logic [1:0] rise_pe = 2'b00;
    logic [1:0] rise_fe = 2'b00;

    always #5 sys_clk = ~sys_clk;

    uart_recv_cfg #(.BPS_CNT(16'd16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd[0]), .uart_ready(ready[0]),
        .uart_valid(valid[0]), .uart_data(data_bus[7:0]), .par_err(pe[0]), .frm_err(fe[0]),
        .overrun(ovr[0]), .fsm_state(st0)
    );

    uart_recv_cfg #(.BPS_CNT(16'd16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd[1]), .uart_ready(ready[1]),
        .uart_valid(valid[1]), .uart_data(data_bus[15:8]), .par_err(pe[1]), .frm_err(fe[1]),
        .overrun(ovr[1]), .fsm_state(st1)
    );

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, id, act, exp, cyc);
        end
    endtask

    // Output register model: completions arrive at their computed cycle.
    always @(posedge sys_clk or negedge sys_rst_n) begin : model
        logic [42:0] ent;
        logic        comp;
        if (!sys_rst_n) begin
            m_valid = 2'b00;
            m_pe    = 2'b00;
            m_fe    = 2'b00;
            m_ovr   = 2'b00;
            m_data[0] = 8'h00;
            m_data[1] = 8'h00;
            exp_q.delete();
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                comp     = 1'b0;
                m_ovr[i] = 1'b0;
                if (exp_q.size() != 0 && exp_q[0][42] == 1'(i) && int'(exp_q[0][41:10]) == cyc) begin
                    comp = 1'b1;
                    ent  = exp_q.pop_front();
                    if (!m_valid[i] || ready[i]) begin
                        m_valid[i] = 1'b1;
                        m_data[i]  = ent[9:2];
                        m_pe[i]    = ent[1];
                        m_fe[i]    = ent[0];
                    end else begin
                        m_ovr[i] = 1'b1;
                    end
                end
                if (!comp && m_valid[i] && ready[i]) m_valid[i] = 1'b0;
            end
        end
    end

    // Compare process and event recording.
    always @(negedge sys_clk) begin
        for (int i = 0; i < 2; i++) begin
            check("valid", i, 32'(valid[i]), 32'(m_valid[i]));
            check("data",  i, 32'(data_bus[i*8 +: 8]), 32'(m_data[i]));
            check("par_err", i, 32'(pe[i]), 32'(m_pe[i]));
            check("frm_err", i, 32'(fe[i]), 32'(m_fe[i]));
            check("overrun", i, 32'(ovr[i]), 32'(m_ovr[i]));
            if (valid[i] && !prev_valid[i]) begin
                rise_cyc[i]  = cyc;
                rise_cnt[i]++;
                rise_data[i] = data_bus[i*8 +: 8];
                rise_pe[i]   = pe[i];
                rise_fe[i]   = fe[i];
            end
            if (!valid[i] && prev_valid[i]) fall_cyc[i] = cyc;
            if (ovr[i]) ovr_cnt[i]++;
            prev_valid[i] = valid[i];
        end
    end

    // Drives one frame on rxd[id], starting at the current falling edge.
    // gl: line bit index that gets a 1-cycle inversion at mid-bit (none if
    // out of range). ab: line bit at which reset is asserted mid-bit (-1 none).
    task automatic send(input int id, input logic [7:0] d, input bit flip, input bit s1v,
                        input bit s2v, input int gl, input int ab, output int p0);
        logic       lb [12];
        int         n;
        int         nb;
        int         pm;
        int         ns;
        logic [7:0] mask;
        logic [7:0] xd;
        logic       x;
        logic       pb;
        logic       epe;
        logic       efe;
        nb   = (id == 0) ? 8 : 7;
        pm   = (id == 0) ? 0 : 2;
        ns   = (id == 0) ? 1 : 2;
        mask = 8'((9'd1 << nb) - 9'd1);
        xd   = d & mask;
        x    = ^xd;
        n    = 0;
        lb[n] = 1'b0; n++;
        for (int i = 0; i < nb; i++) begin
            lb[n] = xd[i]; n++;
        end
        epe = 1'b0;
        if (pm != 0) begin
            pb = ((pm == 2) ? x : ~x) ^ flip;
            lb[n] = pb; n++;
            epe = (pm == 1) ? ((x ^ pb) == 1'b0) : ((x ^ pb) == 1'b1);
        end
        lb[n] = s1v; n++;
        if (ns == 2) begin
            lb[n] = s2v; n++;
        end
        efe = !s1v || (ns == 2 && !s2v);
        p0  = cyc;
        if (ab < 0)
            exp_q.push_back({1'(id), 32'(p0 + (n - 1) * B + B / 2 + 5), xd, epe, efe});
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < B; j++) begin
                if (k == ab && j == B / 2) begin
                    #1;
                    sys_rst_n = 1'b0;
                    rxd[id]   = 1'b1;
                    return;
                end
                rxd[id] = (k == gl && j == B / 2) ? ~lb[k] : lb[k];
                @(negedge sys_clk);
            end
        end
        rxd[id] = 1'b1;
    endtask

    initial begin
        int  p0;
        int  pd;
        int  rc;
        int  oc;
        bit  rand_done;

        repeat (4) @(negedge sys_clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_valid", i, 32'(valid[i]), 32'd0);
            check("rst_data", i, 32'(data_bus[i*8 +: 8]), 32'h00);
            check("rst_flags", i, {29'd0, pe[i], fe[i], ovr[i]}, 32'd0);
        end
        check("rst_state", 0, 32'(st0), 32'd0);
        check("rst_state", 1, 32'(st1), 32'd0);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        // 8N1 baseline: 0xA5, valid for one cycle at the formula cycle.
        send(0, 8'hA5, 1'b0, 1'b1, 1'b1, -1, -1, p0);
        repeat (20) @(negedge sys_clk);
        check("a5_latency", 0, 32'(rise_cyc[0] - p0), 32'd157);
        check("a5_data", 0, 32'(rise_data[0]), 32'hA5);
        check("a5_flags", 0, {30'd0, rise_pe[0], rise_fe[0]}, 32'd0);
        check("a5_width", 0, 32'(fall_cyc[0] - rise_cyc[0]), 32'd1);

        // 7E2: good parity, bad parity, bad second stop bit.
        send(1, 8'h35, 1'b0, 1'b1, 1'b1, -1, -1, p0);
        repeat (10) @(negedge sys_clk);
        check("7e2_latency", 1, 32'(rise_cyc[1] - p0), 32'd173);
        check("7e2_data", 1, 32'(rise_data[1]), 32'h35);
        check("7e2_pe_ok", 1, 32'(rise_pe[1]), 32'd0);
        send(1, 8'h35, 1'b1, 1'b1, 1'b1, -1, -1, p0);
        repeat (10) @(negedge sys_clk);
        check("7e2_pe_bad_data", 1, 32'(rise_data[1]), 32'h35);
        check("7e2_pe_bad", 1, 32'(rise_pe[1]), 32'd1);
        send(1, 8'h35, 1'b0, 1'b1, 1'b0, -1, -1, p0);
        repeat (10) @(negedge sys_clk);
        check("7e2_fe", 1, {30'd0, rise_pe[1], rise_fe[1]}, 32'd1);

        // Short low pulse while idle is rejected.
        rc = rise_cnt[0];
        rxd[0] = 1'b0;
        repeat (4) @(negedge sys_clk);
        rxd[0] = 1'b1;
        repeat (3 * B) @(negedge sys_clk);
        check("false_start", 0, 32'(rise_cnt[0]), 32'(rc));
        check("false_start_idle", 0, 32'(st0), 32'd0);
        // Mid-bit glitch on data bit 3 (line bit 4) of 0x00 is voted out.
        send(0, 8'h00, 1'b0, 1'b1, 1'b1, 4, -1, p0);
        repeat (10) @(negedge sys_clk);
        check("glitch_cnt", 0, 32'(rise_cnt[0]), 32'(rc + 1));
        check("glitch_data", 0, 32'(rise_data[0]), 32'h00);

        // Overrun: consumer stalled across two frames.
        ready[0] = 1'b0;
        oc = ovr_cnt[0];
        send(0, 8'h11, 1'b0, 1'b1, 1'b1, -1, -1, p0);
        send(0, 8'h22, 1'b0, 1'b1, 1'b1, -1, -1, p0);
        repeat (10) @(negedge sys_clk);
        check("ovr_hold_valid", 0, 32'(valid[0]), 32'd1);
        check("ovr_hold_data", 0, 32'(data_bus[7:0]), 32'h11);
        check("ovr_pulses", 0, 32'(ovr_cnt[0] - oc), 32'd1);
        ready[0] = 1'b1;
        @(negedge sys_clk);
        ready[0] = 1'b0;
        @(negedge sys_clk);
        check("ovr_drain", 0, 32'(valid[0]), 32'd0);

        // Accept exactly in the completion cycle of 0x22.
        send(0, 8'h11, 1'b0, 1'b1, 1'b1, -1, -1, p0);
        oc = ovr_cnt[0];
        rc = rise_cnt[0];
        pd = cyc;
        fork
            send(0, 8'h22, 1'b0, 1'b1, 1'b1, -1, -1, p0);
            begin
                repeat (156) @(negedge sys_clk);
                ready[0] = 1'b1;
                @(negedge sys_clk);
                ready[0] = 1'b0;
            end
        join
        repeat (5) @(negedge sys_clk);
        check("sim_start", 0, 32'(p0), 32'(pd));
        check("sim_data", 0, 32'(data_bus[7:0]), 32'h22);
        check("sim_valid", 0, 32'(valid[0]), 32'd1);
        check("sim_no_ovr", 0, 32'(ovr_cnt[0] - oc), 32'd0);
        check("sim_no_rise", 0, 32'(rise_cnt[0] - rc), 32'd0);
        ready[0] = 1'b1;
        repeat (3) @(negedge sys_clk);

        // Reset during data bit 4 (line bit 5), then a clean frame.
        send(0, 8'hC3, 1'b0, 1'b1, 1'b1, -1, 5, p0);
        repeat (3) @(negedge sys_clk);
        check("mid_rst_valid", 0, 32'(valid[0]), 32'd0);
        check("mid_rst_data", 0, 32'(data_bus[7:0]), 32'h00);
        check("mid_rst_flags", 0, {29'd0, pe[0], fe[0], ovr[0]}, 32'd0);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        rc = rise_cnt[0];
        send(0, 8'h5A, 1'b0, 1'b1, 1'b1, -1, -1, p0);
        repeat (20) @(negedge sys_clk);
        check("post_rst_cnt", 0, 32'(rise_cnt[0] - rc), 32'd1);
        check("post_rst_data", 0, 32'(rise_data[0]), 32'h5A);

        // Randomized frames, errors, glitches and consumer back-pressure.
        rand_done = 1'b0;
        fork
            begin
                for (int t = 0; t < 40; t++) begin
                    int id;
                    id = $urandom_range(0, 1);
                    send(id, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                         ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0),
                         $urandom_range(0, 14), -1, p0);
                    repeat ($urandom_range(1, 20)) @(negedge sys_clk);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge sys_clk);
                    ready = 2'($urandom_range(0, 3));
                end
            end
        join
        ready = 2'b11;
        repeat (3 * B) @(negedge sys_clk);
        check("queue_drained", 0, 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_recv_cfg.md
# uart_recv_cfg

Parametrised UART receiver and successor to the fixed 8N1 receiver. Accepts 5–8 data bits, none/odd/even parity and 1 or 2 stop bits. Adds 3-sample majority voting, false-start rejection, parity and framing error flags, and a valid/ready output register with overrun detection. It sits between the board RX pin and the command parser or FIFO in the UART loopback design.

## Interface
Parameters:
- BPS_CNT, 16'd434: sys_clk cycles per bit (50 MHz / 115200); legal range 8..65535.
- DATA_BITS, 8: data bits per frame; legal values 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports (one clock; reset is asynchronous and active-low):
- sys_clk  input  1  system clock
- sys_rst_n  input  1  asynchronous active-low reset
- uart_rxd  input  1  serial line, idle high, asynchronous to sys_clk
- uart_ready  input  1  consumer accepts uart_data this cycle
- uart_valid  output  1  uart_data and error flags hold a received frame
- uart_data  output  8  received word, LSB first on the line; bits [7:DATA_BITS] are 0
- par_err  output  1  parity mismatch for the frame held; 0 when PARITY=0
- frm_err  output  1  a stop bit was sampled 0 for the frame held
- overrun  output  1  one-cycle pulse: a completed frame was dropped

## Operation
- **Synchronizer:** uart_rxd passes through two flops, rxd_s1 then rxd_s2. Both reset to 1 so reset release does not create a false start.
- **Start detect:** a falling edge is rxd_s2 = 0 while its previous value = 1. It is honoured only in IDLE.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on falling edge. clk_cnt = 0 and bit_cnt = 0 on entry.
  - START → IDLE if the start vote = 1. This is a glitch: no output and no flag.
  - START → DATA if the start vote = 0.
  - DATA → PARITY after DATA_BITS votes if PARITY ≠ 0, otherwise DATA → STOP.
  - PARITY → STOP after one vote.
  - STOP → IDLE after STOP_BITS votes.
- **Bit timer:** clk_cnt counts 0..BPS_CNT-1 in each bit, then wraps to 0 and advances the bit.
- **Majority vote:** rxd_s2 is captured at clk_cnt = BPS_CNT/2-1, BPS_CNT/2 and BPS_CNT/2+1. The vote is the majority of the three and is evaluated at clk_cnt = BPS_CNT/2+1. Integer division.
- **Data assembly:** data votes shift in LSB first. Unused high bits are forced to 0.
- **Parity check:** computed as XOR of the data bits. Odd mode errors when XOR(data) XOR parity_bit = 0. Even mode errors when it = 1.
- **Stop bits:** frm_err is set if any stop vote = 0. With STOP_BITS = 2 both stop bits are checked.
- **Early return to IDLE:** the FSM returns to IDLE immediately after the last stop vote, so a start edge in the remaining half stop bit is caught.
- **Frame completion:** at the last stop vote the frame is offered to the output register. If the frame has a framing error, its data is still delivered with frm_err = 1.
- **Output register:**
  - Load when uart_valid = 0, or uart_valid = 1 and uart_ready = 1 in the same cycle. uart_valid then stays or goes to 1 with the new data and flags, and no overrun is raised.
  - If uart_valid = 1 and uart_ready = 0 at completion, the new frame is discarded, the held frame is unchanged, and overrun pulses for 1 cycle.
  - uart_valid && uart_ready with no completion in that cycle: uart_valid → 0, while data and flags keep their values.
- **Reset:** any time, including mid-frame, reset aborts the frame. The FSM goes to IDLE and all outputs go to 0. The line must return high (a falling edge is needed) before the next frame is received.

## Timing
- Reset values: uart_valid = 0, uart_data = 8'h00, par_err = 0, frm_err = 0, overrun = 0.
- Pin-to-edge delay: 2 cycles through the synchronizer. Let E be the cycle in which the edge is detected.
- Decision for line bit k (start bit is k = 0) occurs at cycle E + 1 + k·BPS_CNT + BPS_CNT/2 + 1.
- Frame length N = 1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS.
- uart_valid rises at E + (N-1)·BPS_CNT + BPS_CNT/2 + 3 (registered, 1 cycle after the last decision).
- uart_valid may stay high indefinitely. No data changes while uart_valid = 1 && uart_ready = 0.
- Tolerance: ±1 sampled-cycle glitches inside a bit are masked by the vote.
- Combined clock/baud error must stay below ±4% across N bits.

## Test plan
- **8N1 baseline** (BPS_CNT = 16, uart_ready = 1): send 0xA5 → one cycle of uart_valid with uart_data = 0xA5 and par_err = frm_err = 0, at the cycle given by the formula above.
- **7E2:** send 0x35 with parity bit 0 → data 0x35, par_err = 0. Send 0x35 with parity bit 1 → data 0x35, par_err = 1. Send a stop2 = 0 frame → frm_err = 1.
- **Glitch:** drive a 4-cycle low pulse on uart_rxd while idle → no uart_valid. Inject a 1-cycle inverted glitch at mid-bit of data bit 3 of 0x00 → data 0x00.
- **Overrun:** with uart_ready = 0, send 0x11 then 0x22 → uart_valid holds 0x11 and overrun pulses once at the second completion. Raise uart_ready → uart_valid falls.
- **Simultaneous accept/complete:** assert uart_ready exactly at the completion cycle of 0x22 → uart_data = 0x22, uart_valid stays 1, overrun = 0.
- **Reset mid-frame:** assert sys_rst_n = 0 at data bit 4 → all outputs 0. Send a new frame 0x5A after release → 0x5A received correctly, with no spurious frame.
